// File: rtl/min_width_line_tx.sv
// Minimum-width line transmitter: queued {level, length} commands drive a
// one-bit line whose every segment lasts at least MIN_HOLD cycles.
//
// Ports:
//   clk, rst   rising-edge clock, async active-high reset
//   cmd_valid  command offered
//   cmd_ready  command FIFO has room (from registered count)
//   cmd_level  level to drive for the segment
//   cmd_len    requested segment length in cycles
//   line_out   registered line output
//   busy       a segment is counting (state HOLD)
//   seg_start  one-cycle pulse on the first cycle of each segment
//   fifo_cnt   commands currently queued
module min_width_line_tx #(
  parameter int   MIN_HOLD   = 4,
  parameter int   LEN_W      = 8,
  parameter int   FIFO_DEPTH = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_level,
  input  logic [LEN_W-1:0]            cmd_len,
  output logic                        line_out,
  output logic                        busy,
  output logic                        seg_start,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_HOLD);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t state;
  state_t state_nx;

  logic [LEN_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [LEN_W-1:0] counter;
  logic [LEN_W-1:0] counter_nx;
  logic             line_q;
  logic             line_nx;
  logic             seg_q;
  logic             seg_nx;
  logic             push;
  logic             pop;
  logic             head_level;
  logic [LEN_W-1:0] head_len;
  logic [LEN_W-1:0] eff_len;

  assign cmd_ready = (count != FULL_C);
  assign push      = cmd_valid & cmd_ready;

  assign {head_level, head_len} = mem[rd_ptr];

  // Short or zero requests are stretched to the minimum hold.
  assign eff_len = (head_len < MIN_L) ? MIN_L : head_len;

  always_comb begin
    state_nx   = state;
    counter_nx = counter;
    line_nx    = line_q;
    seg_nx     = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) pop = 1'b1;
      end
      HOLD: begin
        if (counter == '0) begin
          // Back-to-back segments: the next one starts with no gap.
          if (count != '0) pop = 1'b1;
          else state_nx = IDLE;
        end else begin
          counter_nx = counter - 1'b1;
        end
      end
    endcase
    if (pop) begin
      state_nx   = HOLD;
      line_nx    = head_level;
      seg_nx     = 1'b1;
      counter_nx = eff_len - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      line_q  <= IDLE_LEVEL;
      seg_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      counter <= counter_nx;
      line_q  <= line_nx;
      seg_q   <= seg_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_level, cmd_len};
  end

  assign line_out  = line_q;
  assign seg_start = seg_q;
  assign busy      = (state == HOLD);
  assign fifo_cnt  = count;

endmodule

// File: tb/tb_min_width_line_tx.sv
// Testbench for min_width_line_tx: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference of the line.
module tb_min_width_line_tx;

  localparam int MIN_HOLD = 4;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_level = 1'b0;
  logic [7:0] cmd_len = '0;
  logic       line_out;
  logic       busy;
  logic       seg_start;
  logic [2:0] fifo_cnt;

  int checks = 0;
  int errors = 0;

  // Reference: pending segments and cycles left in the current one.
  int   q_lvl[$];
  int   q_len[$];
  int   m_rem  = 0;
  logic m_line = 1'b0;
  logic m_seg  = 1'b0;

  // Run-length tracking for the minimum-width property.
  logic prev_line = 1'b0;
  int   run_len   = 0;
  bit   run_ok    = 1'b0;

  int   high_cnt;
  int   seg_cnt;
  int   edge_cnt;
  bit   acc;
  int   tries;

  always #5 clk = ~clk;

  min_width_line_tx #(
    .MIN_HOLD(MIN_HOLD),
    .LEN_W(8),
    .FIFO_DEPTH(DEPTH),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_level(cmd_level),
    .cmd_len(cmd_len),
    .line_out(line_out),
    .busy(busy),
    .seg_start(seg_start),
    .fifo_cnt(fifo_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_lvl.delete();
    q_len.delete();
    m_rem     = 0;
    m_line    = 1'b0;
    m_seg     = 1'b0;
    prev_line = 1'b0;
    run_ok    = 1'b0;
    run_len   = 0;
  endtask

  // One clock: offer a command, advance the reference, compare outputs.
  task automatic step(input bit v, input bit lv, input int ln,
                      output bit accepted);
    bit rdy;
    bit pop;
    cmd_valid = v;
    cmd_level = lv;
    cmd_len   = ln[7:0];
    rdy = (q_lvl.size() < DEPTH);
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, rdy});
    @(posedge clk);
    accepted = v && rdy;
    pop = (q_lvl.size() > 0) && (m_rem <= 1);
    if (pop) begin
      m_line = q_lvl.pop_front() != 0;
      m_rem  = q_len.pop_front();
      m_seg  = 1'b1;
    end else begin
      if (m_rem > 0) m_rem--;
      m_seg = 1'b0;
    end
    if (accepted) begin
      q_lvl.push_back(int'(lv));
      q_len.push_back(ln < MIN_HOLD ? MIN_HOLD : ln);
    end
    #1;
    cmd_valid = 1'b0;
    chk("line_out", {31'd0, line_out}, {31'd0, m_line});
    chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
    chk("seg_start", {31'd0, seg_start}, {31'd0, m_seg});
    chk("fifo_cnt", {29'd0, fifo_cnt}, q_lvl.size());
    if (line_out !== prev_line) begin
      if (run_ok) chk("min_run", {31'd0, run_len >= MIN_HOLD}, 1);
      run_len = 1;
      run_ok  = 1'b1;
    end else begin
      run_len++;
    end
    prev_line = line_out;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 0, a);
      if (line_out === 1'b1) high_cnt++;
      if (seg_start === 1'b1) seg_cnt++;
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_line", {31'd0, line_out}, 0);
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_seg", {31'd0, seg_start}, 0);
    chk("rst_cnt", {29'd0, fifo_cnt}, 0);
    model_reset();
    #2 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #13 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("init_line", {31'd0, line_out}, 0);
    chk("init_ready", {31'd0, cmd_ready}, 1);

    // Single long high segment from idle.
    step(1'b1, 1'b1, 10, acc);
    chk("t2_cnt", {29'd0, fifo_cnt}, 1);
    chk("t2_line0", {31'd0, line_out}, 0);
    step(1'b0, 1'b0, 0, acc);
    chk("t2_start", {31'd0, seg_start}, 1);
    chk("t2_line1", {31'd0, line_out}, 1);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 0, acc);
      chk("t2_hold", {30'd0, busy, line_out}, 3);
    end
    step(1'b0, 1'b0, 0, acc);
    chk("t2_end", {30'd0, busy, line_out}, 1);
    idle(5);
    chk("t2_keep", {31'd0, line_out}, 1);

    // Reset in the middle of a segment with one command queued.
    step(1'b1, 1'b0, 10, acc);
    step(1'b1, 1'b1, 5, acc);
    step(1'b0, 1'b0, 0, acc);
    async_reset();

    // Short requests are stretched to the minimum hold.
    high_cnt = 0;
    step(1'b1, 1'b1, 1, acc);
    step(1'b1, 1'b0, 0, acc);
    if (line_out === 1'b1) high_cnt++;
    idle(12);
    chk("t3_high", high_cnt, 4);
    chk("t3_low", {31'd0, line_out}, 0);

    // Same-level segments: no edge, two start pulses.
    seg_cnt  = 0;
    high_cnt = 0;
    step(1'b1, 1'b0, 6, acc);
    step(1'b1, 1'b0, 6, acc);
    if (seg_start === 1'b1) seg_cnt++;
    idle(16);
    chk("t5_seg", seg_cnt, 2);
    chk("t5_high", high_cnt, 0);

    // Fill the FIFO behind a running segment.
    step(1'b1, 1'b1, 8, acc);
    step(1'b0, 1'b0, 0, acc);
    for (int i = 0; i < 4; i++) step(1'b1, i[0], 4 + i, acc);
    chk("t4_full", {31'd0, cmd_ready}, 0);
    chk("t4_cnt", {29'd0, fifo_cnt}, 4);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 50) begin
      step(1'b1, 1'b1, 5, acc);
      tries++;
    end
    chk("t4_fifth", {31'd0, acc}, 1);
    idle(40);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 20), acc);
    end
    idle(120);
    chk("final_idle", {31'd0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
